pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 18, SHALL set the width of all measurement counters and outputs.
REQ-002 Parameter TIMEOUT, default 262143, SHALL set the cycle count without an edge after which the input is declared dead.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 pwm_in  input  1  SHALL be the asynchronous PWM waveform under measurement.
REQ-006 high_count  output  CNT_W  SHALL hold the high time of the last complete period, in clk cycles.
REQ-007 period_count  output  CNT_W  SHALL hold the rising-to-rising length of the last complete period, in clk cycles.
REQ-008 valid  output  1  SHALL pulse high for exactly one cycle when high_count/period_count update.
REQ-009 no_signal  output  1  SHALL be high while no valid PWM activity is present.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; the edge detector SHALL compare the synchronized level with its one-cycle-delayed copy to produce rise and fall pulses.
REQ-011 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-012 IDLE: counters held at 0; a rise SHALL move to HIGH with both counters loaded to 1.
REQ-013 HIGH: high and period counters SHALL increment each cycle; a fall SHALL move to LOW, freezing the high counter.
REQ-014 LOW: period counter SHALL increment each cycle; a rise SHALL complete the period.
REQ-015 On period completion the FSM SHALL register high_count and period_count, assert valid on the next cycle, reload counters to 1 and enter HIGH in the same cycle, so back-to-back periods lose no cycles.
REQ-016 For an ideal input high for H cycles and low for L cycles (H, L >= 1), outputs SHALL report high_count = H and period_count = H + L.
REQ-017 Latency: valid SHALL assert 4 clk edges after the first edge sampling the period-ending pwm_in rise.
REQ-018 high_count/period_count SHALL hold their last values until the next valid; they SHALL NOT change while valid is low.
REQ-019 If the period counter reaches TIMEOUT in HIGH or LOW, the FSM SHALL enter IDLE, assert no_signal and not pulse valid; counters SHALL never wrap.
REQ-020 no_signal SHALL be high in IDLE and fall in the cycle valid first asserts; the first rise after IDLE SHALL NOT produce valid (partial period discarded).
REQ-021 A constant-high or constant-low input SHALL yield no_signal = 1 within TIMEOUT + 4 cycles and no valid pulses.
REQ-022 TIMEOUT SHALL be <= 2^CNT_W - 1; elaboration SHALL fail otherwise.

Reset
REQ-023 With reset high at a clk edge: FSM to IDLE, synchronizer and edge flops to 0, counters 0, high_count 0, period_count 0, valid 0, no_signal 1.
REQ-024 Reset mid-measurement SHALL discard the partial period; the first valid after reset SHALL require two full rising edges of pwm_in.
REQ-025 Reset SHALL take priority over edge detection and timeout in the same cycle.

Structure
REQ-026 Package pwm_pkg SHALL hold the FSM state type (IDLE/HIGH/LOW) and default CNT_W/TIMEOUT constants shared with PWM_generator benches.
REQ-027 The synchronizer and edge detector SHALL be a sub-module pwm_edge_sync (ports clk, reset, in, level, rise, fall).

Verification
REQ-028 Periodic input high 5, low 15 cycles -> from the 2nd rise onward valid every 20 cycles with high_count = 5, period_count = 20; no_signal falls with first valid.
REQ-029 Minimum pulse: high 1, low 1 cycle, repeated -> high_count = 1, period_count = 2, valid every 2 cycles.
REQ-030 TIMEOUT = 100, pwm_in stuck high after one valid period -> no valid, no_signal = 1 at cycle <= 104 after last rise; restore the 5/15 waveform -> valid again after two rises.
REQ-031 Reset asserted 3 cycles into a HIGH phase -> all outputs at reset values next cycle; first post-reset valid only after the second rise.
REQ-032 Drive from PWM_generator at default settings -> high_count = 20001 and period_count = 200000 on every valid.
REQ-033 Duty change from 5/15 to 12/8 mid-stream -> the period spanning the change reports its own H and H + L exactly; no valid dropped.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block and the PWM generator benches.
//   CNT_W_DEFAULT   : default measurement counter width
//   TIMEOUT_DEFAULT : default dead-input cycle limit
//   pwm_state_e     : capture FSM state encoding
package pwm_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 18;
    localparam int unsigned TIMEOUT_DEFAULT = 262143;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus edge detector for an asynchronous input.
//   clk   : clock
//   reset : synchronous active-high reset
//   in    : asynchronous input
//   level : synchronized level
//   rise  : one-cycle pulse on a synchronized 0->1 transition
//   fall  : one-cycle pulse on a synchronized 1->0 transition
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronizer chain and one-cycle-delayed copy of the synchronized level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;
    assign fall  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input.
//   clk          : clock
//   reset        : synchronous active-high reset
//   pwm_in       : asynchronous PWM waveform
//   high_count   : high time of the last complete period (cycles)
//   period_count : rise-to-rise length of the last complete period (cycles)
//   valid        : one-cycle pulse when high_count/period_count update
//   no_signal    : high while no valid PWM activity is present
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             no_signal
);

    // The period counter must be able to reach TIMEOUT without wrapping
    if (64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT does not fit in CNT_W bits");
    end

    logic level;
    logic rise;
    logic fall;
    logic unused_level;

    pwm_edge_sync u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .in    (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign unused_level = level;

    pwm_state_e       state_q,        state_d;
    logic [CNT_W-1:0] hcnt_q,         hcnt_d;
    logic [CNT_W-1:0] pcnt_q,         pcnt_d;
    logic [CNT_W-1:0] hcap_q,         hcap_d;
    logic [CNT_W-1:0] pcap_q,         pcap_d;
    logic             done_q,         done_d;
    logic [CNT_W-1:0] high_count_q,   high_count_d;
    logic [CNT_W-1:0] period_count_q, period_count_d;
    logic             valid_q,        valid_d;
    logic             no_signal_q,    no_signal_d;
    logic             timeout_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hcnt_q         <= '0;
            pcnt_q         <= '0;
            hcap_q         <= '0;
            pcap_q         <= '0;
            done_q         <= 1'b0;
            high_count_q   <= '0;
            period_count_q <= '0;
            valid_q        <= 1'b0;
            no_signal_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            pcnt_q         <= pcnt_d;
            hcap_q         <= hcap_d;
            pcap_q         <= pcap_d;
            done_q         <= done_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            valid_q        <= valid_d;
            no_signal_q    <= no_signal_d;
        end
    end

    assign timeout_c = (pcnt_q == CNT_W'(TIMEOUT));

    // Next-state logic; a completed period is captured, then published one cycle later
    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        pcnt_d         = pcnt_q;
        hcap_d         = hcap_q;
        pcap_d         = pcap_q;
        done_d         = 1'b0;
        high_count_d   = high_count_q;
        period_count_d = period_count_q;
        valid_d        = 1'b0;
        no_signal_d    = no_signal_q;

        if (done_q) begin
            high_count_d   = hcap_q;
            period_count_d = pcap_q;
            valid_d        = 1'b1;
            no_signal_d    = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                hcnt_d = '0;
                pcnt_d = '0;
                // First rise only starts a measurement; no result yet
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                    pcnt_d  = CNT_W'(1);
                end
            end
            HIGH: begin
                if (timeout_c) begin
                    state_d     = IDLE;
                    hcnt_d      = '0;
                    pcnt_d      = '0;
                    no_signal_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                    if (fall) begin
                        state_d = LOW;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                    end
                end
            end
            LOW: begin
                if (timeout_c) begin
                    state_d     = IDLE;
                    hcnt_d      = '0;
                    pcnt_d      = '0;
                    no_signal_d = 1'b1;
                end else if (rise) begin
                    // Period complete: capture and restart with no lost cycle
                    hcap_d  = hcnt_q;
                    pcap_d  = pcnt_q;
                    done_d  = 1'b1;
                    hcnt_d  = CNT_W'(1);
                    pcnt_d  = CNT_W'(1);
                    state_d = HIGH;
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                hcnt_d      = '0;
                pcnt_d      = '0;
                no_signal_d = 1'b1;
            end
        endcase
    end

    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign valid        = valid_q;
    assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT = 100.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 18;
    localparam int unsigned TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic             pwm_in;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic             valid;
    logic             no_signal;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .no_signal    (no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   h;
        int   p;
        logic ns;
        logic ns_prev;
    } vrec_t;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    vrec_t vq[$];
    int    rise_q[$];
    vrec_t rec;
    logic  ns_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every valid pulse with its cycle number and the no_signal history
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            rec.cyc     = cyc;
            rec.h       = int'(high_count);
            rec.p       = int'(period_count);
            rec.ns      = no_signal;
            rec.ns_prev = ns_prev;
            vq.push_back(rec);
        end
        ns_prev = no_signal;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One PWM period starting with a rise; called at a falling clock edge
    task automatic pulse(input int h, input int l);
        rise_q.push_back(cyc);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_valids(input string tag, input int n_exp, input int h_exp, input int p_exp);
        check_eq({tag, "_count"}, 32'(vq.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < vq.size(); i++) begin
            check_eq({tag, "_h"},   32'(vq[i].h), 32'(h_exp));
            check_eq({tag, "_p"},   32'(vq[i].p), 32'(p_exp));
            check_eq({tag, "_lat"}, 32'(vq[i].cyc - rise_q[i+1]), 32'd4);
        end
    endtask

    int exp_h [12] = '{5, 5, 5, 5, 5, 12, 12, 12, 1, 1, 1, 1};
    int exp_p [12] = '{20, 20, 20, 20, 20, 20, 20, 20, 2, 2, 2, 2};
    int t0;

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_high",   32'(high_count),   32'd0);
        check_eq("rst_period", 32'(period_count), 32'd0);
        check_eq("rst_valid",  32'(valid),        32'd0);
        check_eq("rst_nosig",  32'(no_signal),    32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 5/15 stream, duty change to 12/8, then minimum 1/1 pulses
        vq.delete();
        rise_q.delete();
        repeat (5) pulse(5, 15);
        repeat (3) pulse(12, 8);
        repeat (4) pulse(1, 1);
        rise_q.push_back(cyc);
        t0     = cyc;
        pwm_in = 1'b1;
        repeat (102) @(negedge clk);
        check_eq("stream_count", 32'(vq.size()), 32'd12);
        for (int i = 0; i < 12 && i < vq.size(); i++) begin
            check_eq("stream_h",   32'(vq[i].h), 32'(exp_h[i]));
            check_eq("stream_p",   32'(vq[i].p), 32'(exp_p[i]));
            check_eq("stream_lat", 32'(vq[i].cyc - rise_q[i+1]), 32'd4);
        end
        if (vq.size() >= 12) begin
            check_eq("first_ns_before", 32'(vq[0].ns_prev), 32'd1);
            check_eq("first_ns_after",  32'(vq[0].ns),      32'd0);
            check_eq("min_gap",         32'(vq[11].cyc - vq[10].cyc), 32'd2);
        end

        // Stuck high: no_signal must rise between 102 and 104 cycles after the last rise
        check_eq("timeout_early_ns", 32'(no_signal), 32'd0);
        check_eq("timeout_cyc", 32'(cyc - t0), 32'd102);
        repeat (2) @(negedge clk);
        check_eq("timeout_ns",     32'(no_signal),    32'd1);
        check_eq("timeout_hold_h", 32'(high_count),   32'd1);
        check_eq("timeout_hold_p", 32'(period_count), 32'd2);
        repeat (50) @(negedge clk);
        check_eq("timeout_no_valid", 32'(vq.size()), 32'd12);

        // Restore 5/15: the first rise after IDLE must not report
        pwm_in = 1'b0;
        repeat (15) @(negedge clk);
        vq.delete();
        rise_q.delete();
        repeat (3) pulse(5, 15);
        rise_q.push_back(cyc);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check_valids("restore", 3, 5, 20);
        if (vq.size() >= 1) begin
            check_eq("restore_ns_before", 32'(vq[0].ns_prev), 32'd1);
            check_eq("restore_ns_after",  32'(vq[0].ns),      32'd0);
        end

        // Reset three cycles into a HIGH phase
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_high",   32'(high_count),   32'd0);
        check_eq("midrst_period", 32'(period_count), 32'd0);
        check_eq("midrst_valid",  32'(valid),        32'd0);
        check_eq("midrst_nosig",  32'(no_signal),    32'd1);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vq.delete();
        rise_q.delete();
        repeat (2) pulse(5, 15);
        rise_q.push_back(cyc);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check_valids("postrst", 2, 5, 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
